sdram_port_arbiter: RTL and testbench

Shares the single-access SDRAM controller between NPORTS independent requesters, such as CPU, video fetch and DMA. Arbitration is round-robin with one outstanding access at a time. The block drives the controller's read/write request, grant and commit handshake, steers read data back to the winning port, and aborts any access that does not complete within a watchdog limit. It sits between the requesters and the memory controller, in the ramclk domain.

---
 rtl/sdram_port_arbiter.sv | 118 +++++++++++
 tb/tb_sdram_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of one SDRAM controller among NPORTS requesters, with watchdog abort.
// Define PORT0_PRIORITY_EN to let port 0 win every arbitration it requests without advancing the round-robin pointer.
module sdram_port_arbiter #(
  parameter int NPORTS = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     ramclk,
  input  logic                     reset_n,
  input  logic [NPORTS-1:0]        port_req,
  input  logic [NPORTS-1:0]        port_we,
  input  logic [NPORTS*ADDR_W-1:0] port_addr,
  input  logic [NPORTS*DATA_W-1:0] port_wdata,
  output logic [DATA_W-1:0]        port_rdata,
  output logic [NPORTS-1:0]        port_rvalid,
  output logic [NPORTS-1:0]        port_done,
  output logic [NPORTS-1:0]        port_err,
  output logic                     mem_read_req,
  input  logic                     mem_read_grant,
  output logic [ADDR_W-1:0]        mem_read_addr,
  input  logic [DATA_W-1:0]        mem_read_data,
  input  logic                     mem_read_valid,
  output logic                     mem_write_req,
  input  logic                     mem_write_grant,
  output logic [ADDR_W-1:0]        mem_write_addr,
  output logic [DATA_W-1:0]        mem_write_data,
  input  logic                     mem_commit,
  output logic                     busy
);
  localparam int IW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  localparam int WW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d, win_q, win_d;
  logic              we_q, req_q, got_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [WW-1:0]     wd_q;
  logic [NPORTS-1:0] done_q, err_q, rvalid_q, req_m, win_oh;
  logic              any, gnt, commit, tmo, fin, rv;

  always_comb begin
    // the port that just finished is masked for one cycle so it can drop its request
`ifdef PORT0_PRIORITY_EN
    req_m = port_req & ~(done_q & ~NPORTS'(1));
`else
    req_m = port_req & ~done_q;
`endif
    any = |req_m;
    win_d = '0;
    for (int k = NPORTS - 1; k >= 0; k--)
      if (req_m[(int'(rr_q) + k) % NPORTS]) win_d = IW'((int'(rr_q) + k) % NPORTS);
`ifdef PORT0_PRIORITY_EN
    if (req_m[0]) win_d = '0;
`endif
    win_oh = NPORTS'(1) << win_q;
    gnt = req_q & (we_q ? mem_write_grant : mem_read_grant);
    commit = state_q == WAIT && mem_commit;
    tmo = state_q != IDLE && !commit && wd_q == WW'(TIMEOUT_CYCLES - 1);
    fin = commit | tmo;
    rv = state_q == WAIT && mem_read_valid && !we_q && !got_q;
    state_d = state_q == IDLE ? (any ? ISSUE : IDLE) :
              fin ? IDLE : (state_q == ISSUE && gnt) ? WAIT : state_q;
`ifdef PORT0_PRIORITY_EN
    rr_d = (!fin || win_q == '0) ? rr_q : win_q == IW'(NPORTS - 1) ? '0 : win_q + 1'b1;
`else
    rr_d = !fin ? rr_q : win_q == IW'(NPORTS - 1) ? '0 : win_q + 1'b1;
`endif
  end

  always_ff @(posedge ramclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      win_q    <= '0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      got_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wd_q     <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      // request drops on the edge after a matching grant so the controller cannot grant twice
      req_q    <= state_q == ISSUE && !gnt && !tmo;
      wd_q     <= state_q == IDLE ? '0 : wd_q + 1'b1;
      got_q    <= state_q != IDLE && (got_q | rv);
      done_q   <= fin ? win_oh : '0;
      err_q    <= tmo ? win_oh : '0;
      rvalid_q <= rv ? win_oh : '0;
      if (rv) rdata_q <= mem_read_data;
      if (state_q == IDLE && any) begin
        win_q   <= win_d;
        we_q    <= port_we[win_d];
        addr_q  <= port_addr[int'(win_d) * ADDR_W +: ADDR_W];
        wdata_q <= port_wdata[int'(win_d) * DATA_W +: DATA_W];
      end
    end
  end

  assign port_rdata     = rdata_q;
  assign port_rvalid    = rvalid_q;
  assign port_done      = done_q;
  assign port_err       = err_q;
  assign mem_read_req   = req_q & ~we_q;
  assign mem_write_req  = req_q & we_q;
  assign mem_read_addr  = addr_q;
  assign mem_write_addr = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = state_q != IDLE;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: random and directed stimulus against a transaction-level model of the arbiter and a simple controller model.
module tb_sdram_port_arbiter;
  localparam int N = 3, AW = 32, DW = 16, TO = 16;

  logic ramclk = 0, reset_n = 1;
  logic [N-1:0] port_req, port_we, port_rvalid, port_done, port_err;
  logic [N*AW-1:0] port_addr;
  logic [N*DW-1:0] port_wdata;
  logic [DW-1:0] port_rdata, mem_read_data, mem_write_data;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic mem_read_req, mem_read_grant, mem_read_valid, mem_write_req, mem_write_grant, mem_commit, busy;

  always #5 ramclk = ~ramclk;

  sdram_port_arbiter #(.NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ramclk(ramclk), .reset_n(reset_n), .port_req(port_req), .port_we(port_we),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_rdata(port_rdata),
    .port_rvalid(port_rvalid), .port_done(port_done), .port_err(port_err),
    .mem_read_req(mem_read_req), .mem_read_grant(mem_read_grant), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
    .mem_write_req(mem_write_req), .mem_write_grant(mem_write_grant),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_commit(mem_commit), .busy(busy));

  int checks = 0, failures = 0;
  logic act[N], rwe[N];
  logic [AW-1:0] raddr[N];
  logic [DW-1:0] rwd[N];
  logic e_busy;
  logic [N-1:0] e_done, e_err, e_rv, last_done, last_rv;
  logic [DW-1:0] e_rdata, last_rdata, k_data;
  int age, m_w, m_rr, rv_cnt, err_cnt;
  int done_log[$];
  int c_st, c_cnt, c_g, c_c, c_rv;
  logic c_ng, c_rd, c_gnt_prev;
  int k_g, k_c, k_rv, k_ng_pct, k_rq_pct;
  logic k_hold, k_data_fix;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int rr);
    for (int k = 0; k < N; k++) if (m[(rr + k) % N]) return (rr + k) % N;
    return 0;
  endfunction

  task automatic new_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    act[p] = 1; rwe[p] = we; raddr[p] = a; rwd[p] = d;
  endtask

  task automatic rand_req(input int p);
    new_req(p, 1'($urandom), $urandom, DW'($urandom));
  endtask

  task automatic drive_ports();
    for (int p = 0; p < N; p++) begin
      port_req[p] = act[p];
      port_we[p] = rwe[p];
      port_addr[p*AW +: AW] = raddr[p];
      port_wdata[p*DW +: DW] = rwd[p];
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin act[p] = 0; rwe[p] = 0; raddr[p] = '0; rwd[p] = '0; end
    drive_ports();
    {mem_read_grant, mem_write_grant, mem_read_valid, mem_commit} = '0;
    mem_read_data = '0;
    e_busy = 0; e_done = '0; e_err = '0; e_rv = '0; e_rdata = '0;
    age = 0; m_w = 0; m_rr = 0; c_st = 0; c_cnt = 0; c_gnt_prev = 0; c_ng = 0; c_rd = 0;
    k_hold = 0;
  endtask

  task automatic rst_checks(input string tag);
    check({tag, "_ctl"}, {busy, mem_read_req, mem_write_req, port_rvalid, port_done, port_err}, '0);
    check({tag, "_rdata"}, port_rdata, '0);
    check({tag, "_raddr"}, mem_read_addr, '0);
    check({tag, "_waddr"}, mem_write_addr, '0);
    check({tag, "_wdata"}, mem_write_data, '0);
  endtask

  task automatic cycle();
    logic rq, wq, nbusy;
    logic [N-1:0] nd, ne, nr, arb, oh;
    int nage;
    @(negedge ramclk);
    rq = mem_read_req; wq = mem_write_req;
    oh = N'(1) << m_w;
    check("busy", busy, e_busy);
    check("done", port_done, e_done);
    check("err", port_err, e_err);
    check("rvalid", port_rvalid, e_rv);
    if (e_rv != 0) check("rdata", port_rdata, e_rdata);
    check("one_req", rq & wq, 1'b0);
    if (!e_busy) check("idle_req", rq | wq, 1'b0);
    if (e_busy && age == 1) check("req_early", rq | wq, 1'b0);
    if (e_busy && age == 2) begin
      check("req_type", {rq, wq}, rwe[m_w] ? 2'b01 : 2'b10);
      check("addr", rwe[m_w] ? mem_write_addr : mem_read_addr, raddr[m_w]);
      if (rwe[m_w]) check("wdata", mem_write_data, rwd[m_w]);
    end
    if (c_gnt_prev) check("req_drop", rq | wq, 1'b0);
    if (port_rvalid != 0) begin rv_cnt++; last_rv = port_rvalid; last_rdata = port_rdata; end
    if (port_err != 0) err_cnt++;
    if (port_done != 0) last_done = port_done;
    for (int p = 0; p < N; p++) begin
      if (port_done[p]) begin done_log.push_back(p); act[p] = 0; if (k_hold) rand_req(p); end
      if (!act[p] && $urandom_range(99) < k_rq_pct) rand_req(p);
    end
    drive_ports();
    {mem_read_grant, mem_write_grant, mem_read_valid, mem_commit} = '0;
    c_gnt_prev = 0; nr = '0;
    if (c_st == 0 && (rq | wq)) begin
      c_rd = rq; c_ng = $urandom_range(99) < k_ng_pct;
      c_g = k_g < 0 ? $urandom_range(3) : k_g;
      c_c = k_c < 0 ? $urandom_range(1, 6) : k_c;
      c_rv = k_rv < 0 ? $urandom_range(1, c_c) : k_rv;
      c_cnt = 0; c_st = 1;
    end
    if (c_st == 1) begin
      if (!c_ng && c_cnt == c_g) begin
        mem_read_grant = c_rd; mem_write_grant = !c_rd; c_gnt_prev = 1; c_st = 2; c_cnt = 0;
      end else begin
        if (c_rd) mem_write_grant = 1'($urandom); else mem_read_grant = 1'($urandom);
        c_cnt++;
      end
    end else if (c_st == 2) begin
      c_cnt++;
      mem_read_data = k_data_fix ? k_data : DW'($urandom);
      if (c_cnt == c_rv) begin
        mem_read_valid = 1;
        if (!rwe[m_w]) begin nr = oh; e_rdata = mem_read_data; end
      end
      if (c_cnt == c_c) begin
        mem_commit = 1; c_st = 0;
        if (c_cnt != c_rv) mem_read_valid = 1'($urandom);
      end
    end
    nd = '0; ne = '0; nbusy = 0; nage = 0;
    if (e_busy) begin
      if (mem_commit) begin nd = oh; m_rr = (m_w + 1) % N; end
      else if (age == TO) begin nd = oh; ne = oh; m_rr = (m_w + 1) % N; c_st = 0; end
      else begin nbusy = 1; nage = age + 1; end
    end else begin
      arb = port_req & ~e_done;
      if (arb != 0) begin m_w = pick(arb, m_rr); nbusy = 1; nage = 1; end
    end
    e_busy = nbusy; age = nage; e_done = nd; e_err = ne; e_rv = nr;
  endtask

  initial begin
    int rv0, er0;
    k_g = -1; k_c = -1; k_rv = -1; k_ng_pct = 0; k_rq_pct = 0; k_data_fix = 0; k_data = '0;
    rv_cnt = 0; err_cnt = 0; last_done = '0; last_rv = '0; last_rdata = '0;
    model_reset();
    #1 reset_n = 0;
    #1 rst_checks("reset");
    repeat (2) cycle();
    reset_n = 1;

    k_g = 1; k_rv = 1; k_c = 5; k_data_fix = 1; k_data = 16'hBEEF;
    new_req(1, 1'b0, 32'h0001_2345, 16'h0);
    repeat (14) cycle();
    check("rd_data", last_rdata, 16'hBEEF);
    check("rd_rvalid", last_rv, 3'b010);
    check("rd_done", last_done, 3'b010);

    rv0 = rv_cnt; k_c = 3;
    new_req(2, 1'b1, 32'h0040_0010, 16'h1234);
    repeat (12) cycle();
    check("wr_done", last_done, 3'b100);
    check("wr_no_rvalid", rv_cnt - rv0, 0);

    er0 = err_cnt; k_ng_pct = 100;
    new_req(0, 1'b0, 32'hCAFE_0000, 16'h0);
    repeat (22) cycle();
    check("wd_err", err_cnt - er0, 1);
    check("wd_done", last_done, 3'b001);

    k_g = -1; k_c = -1; k_rv = -1; k_data_fix = 0; k_ng_pct = 5; k_rq_pct = 30;
    done_log.delete();
    repeat (2000) cycle();
    k_rq_pct = 0; k_ng_pct = 0;
    repeat (80) cycle();
    check("rand_progress", done_log.size() > 100, 1'b1);

    k_g = 0; k_c = 6;
    new_req(2, 1'b0, 32'hA5A5_0000, 16'h0);
    repeat (5) cycle();
    #2 reset_n = 0;
    #1 rst_checks("async_rst");
    model_reset();
    repeat (3) cycle();
    reset_n = 1;

    k_hold = 1; k_g = 0; k_c = 1; k_rv = 1;
    for (int p = 0; p < N; p++) rand_req(p);
    done_log.delete();
    for (int i = 0; i < 80 && done_log.size() < 6; i++) cycle();
    check("rr_count", done_log.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) if (i < done_log.size()) check("rr_order", done_log[i], i % N);
    k_hold = 0;
    repeat (12) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
